// File: rtl/zx_video_render_if.sv
// Video RAM read port between the renderer and the 6912-byte screen RAM.
// The renderer is the master: it issues a registered byte address and gets
// the synchronous read data back one cycle later.
interface zx_video_render_if;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data;

  modport master (output vram_addr, input vram_data);
  modport slave  (input vram_addr, output vram_data);
endinterface

// File: rtl/zx_video_render.sv
// ZX-style 256x192 renderer: pixel-doubles the paper to 512x384 in the
// 640x480 active area, fetches bitmap/attribute bytes one cell ahead of
// the beam and fills the surround with the line-latched border colour.
module zx_video_render #(
  parameter int         CORDW     = 16,
  parameter logic [3:0] LVL_NORM  = 4'hB,
  parameter logic [3:0] LVL_BRT   = 4'hF,
  parameter int         FLASH_BIT = 4
) (
  input  logic                    clk_pix,
  input  logic                    rst,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    de_in,
  input  logic                    frame,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic [2:0]              border,
  zx_video_render_if.master       vram,
  output logic [3:0]              vga_r,
  output logic [3:0]              vga_g,
  output logic [3:0]              vga_b,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_de
);

  localparam logic signed [CORDW-1:0] X_FETCH_LO = CORDW'(-16);
  localparam logic signed [CORDW-1:0] X_FETCH_HI = CORDW'(495);
  localparam logic signed [CORDW-1:0] X_MAX      = CORDW'(511);
  localparam logic signed [CORDW-1:0] Y_MAX      = CORDW'(383);
  localparam logic signed [CORDW-1:0] ZERO       = '0;

  logic [12:0] addr_q;
  logic [7:0]  bm_next, at_next, shifter, attr;
  logic [4:0]  flash_cnt;
  logic [2:0]  border_l;

  logic        x_paper, y_paper, in_paper, in_fetch;
  logic [7:0]  zy;
  logic [4:0]  col;
  logic [3:0]  p;

  assign x_paper  = (sx >= ZERO) && (sx <= X_MAX);
  assign y_paper  = (sy >= ZERO) && (sy <= Y_MAX);
  assign in_paper = x_paper && y_paper;
  assign in_fetch = y_paper && (sx >= X_FETCH_LO) && (sx <= X_FETCH_HI);
  assign zy       = sy[8:1];
  // Column being fetched is the one after the beam's current cell; the
  // +1 also maps sx=-16..-1 onto column 0.
  assign col      = sx[8:4] + 5'd1;
  assign p        = sx[3:0];

  assign vram.vram_addr = addr_q;

  // Fetch sequencer and pixel shifter, keyed on the input phase.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      addr_q  <= '0;
      bm_next <= '0;
      at_next <= '0;
      shifter <= '0;
      attr    <= '0;
    end else begin
      if (x_paper && sx[0]) shifter <= {shifter[6:0], 1'b0};
      if (in_fetch) begin
        case (p)
          4'd0: addr_q <= {zy[7:6], zy[2:0], zy[5:3], col};
          4'd2: begin
            bm_next <= vram.vram_data;
            addr_q  <= 13'h1800 + {3'b000, zy[7:3], col};
          end
          4'd4: at_next <= vram.vram_data;
          4'd15: begin
            shifter <= bm_next;
            attr    <= at_next;
          end
          default: ;
        endcase
      end
    end
  end

  // Flash phase counter and per-line border latch.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      flash_cnt <= '0;
      border_l  <= '0;
    end else begin
      if (frame) flash_cnt <= flash_cnt + 5'd1;
      if (line)  border_l  <= border;
    end
  end

  logic       flash_on;
  logic [2:0] ink, pap, pix;
  logic [3:0] lvl, r_d, g_d, b_d;

  assign flash_on = flash_cnt[FLASH_BIT];

  // Colour select with region priority: blank, paper/ink, border.
  always_comb begin
    ink = attr[2:0];
    pap = attr[5:3];
    if (attr[7] && flash_on) begin
      ink = attr[5:3];
      pap = attr[2:0];
    end
    pix = shifter[7] ? ink : pap;
    lvl = attr[6] ? LVL_BRT : LVL_NORM;
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (!de_in) begin
      r_d = '0;
    end else if (in_paper) begin
      r_d = pix[1] ? lvl : 4'h0;
      g_d = pix[2] ? lvl : 4'h0;
      b_d = pix[0] ? lvl : 4'h0;
    end else begin
      r_d = border_l[1] ? LVL_NORM : 4'h0;
      g_d = border_l[2] ? LVL_NORM : 4'h0;
      b_d = border_l[0] ? LVL_NORM : 4'h0;
    end
  end

  // Output register: colour and syncs share one cycle of latency.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_de <= 1'b0;
    end else begin
      vga_r  <= r_d;
      vga_g  <= g_d;
      vga_b  <= b_d;
      vga_hs <= hsync_in;
      vga_vs <= vsync_in;
      vga_de <= de_in;
    end
  end

endmodule

// File: tb/tb_zx_video_render.sv
// Bench for zx_video_render: random rasters against a coordinate-level
// pixel model, plus literal checks on addresses, pixels, flash and border.
module tb_zx_video_render;
  localparam int CORDW = 16;
  localparam int FLASH_BIT = 4;

  logic clk_pix = 1'b0;
  logic rst = 1'b1;
  logic hsync_in = 1'b1, vsync_in = 1'b1, de_in = 1'b0, frame = 1'b0, line = 1'b0;
  logic signed [CORDW-1:0] sx = '0, sy = '0;
  logic [2:0] border = '0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_de;

  zx_video_render_if vif();

  zx_video_render #(.CORDW(CORDW), .LVL_NORM(4'hB), .LVL_BRT(4'hF), .FLASH_BIT(FLASH_BIT)) dut (
    .clk_pix(clk_pix), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .de_in(de_in), .frame(frame), .line(line), .sx(sx), .sy(sy), .border(border),
    .vram(vif), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
  );

  always #5 clk_pix = ~clk_pix;

  logic [7:0] mem [0:6911];

  always @(posedge clk_pix)
    vif.vram_data <= (vif.vram_addr < 13'd6912) ? mem[vif.vram_addr] : 8'h00;

  int errors = 0, checks = 0;
  int lit_mode = 0;
  int fr_sent = 0;
  int cx, cy;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (sx=%0d sy=%0d)", nm, act, exp, cx, cy);
    end
  endtask

  function automatic logic [11:0] rgb12(input logic [2:0] c, input logic brt);
    logic [3:0] l;
    l = brt ? 4'hF : 4'hB;
    return {c[1] ? l : 4'h0, c[2] ? l : 4'h0, c[0] ? l : 4'h0};
  endfunction

  // What the screen must show at (x,y): read the cell's bytes straight
  // from the RAM image using the ZX memory layout.
  function automatic logic [11:0] paper_rgb(input int x, input int y, input logic [4:0] cnt);
    int zx, zy, c, ba, aa;
    logic [7:0] bm, at;
    logic [2:0] ink, pap, cl;
    zx = x / 2; zy = y / 2; c = x / 16;
    ba = (zy / 64) * 2048 + (zy % 8) * 256 + ((zy / 8) % 8) * 32 + c;
    aa = 6144 + (zy / 8) * 32 + c;
    bm = mem[ba]; at = mem[aa];
    ink = at[2:0]; pap = at[5:3];
    if (at[7] && cnt[FLASH_BIT]) begin ink = at[5:3]; pap = at[2:0]; end
    cl = bm[7 - (zx % 8)] ? ink : pap;
    return rgb12(cl, at[6]);
  endfunction

  // Compare process: model the sample taken at each posedge, check at negedge.
  initial begin
    logic [4:0] m_cnt;
    logic [2:0] m_bl;
    bit m_skip, c_rst, chk_pix;
    logic [11:0] e_rgb;
    logic [2:0] e_sync;
    int c_fr;
    m_cnt = '0; m_bl = '0; m_skip = 1'b1;
    forever begin
      @(posedge clk_pix);
      c_rst = rst; cx = sx; cy = sy; c_fr = fr_sent;
      chk_pix = 1'b1;
      e_rgb = '0;
      if (c_rst) begin
        e_sync = 3'b110;
      end else begin
        e_sync = {hsync_in, vsync_in, de_in};
        if (!de_in) e_rgb = '0;
        else if (cx >= 0 && cx <= 511 && cy >= 0 && cy <= 383) begin
          if (m_skip) chk_pix = 1'b0;
          else e_rgb = paper_rgb(cx, cy, m_cnt);
        end else e_rgb = rgb12(m_bl, 1'b0);
      end
      if (c_rst) begin
        m_cnt = '0; m_bl = '0; m_skip = 1'b1;
      end else begin
        if (frame) m_cnt = m_cnt + 5'd1;
        if (line) begin m_bl = border; m_skip = 1'b0; end
      end
      @(negedge clk_pix);
      if (chk_pix) chk("rgb", {vga_r, vga_g, vga_b}, e_rgb);
      chk("sync", {vga_hs, vga_vs, vga_de}, e_sync);
      if (c_rst) chk("rst_addr", vif.vram_addr, 0);
      if (lit_mode == 1) begin
        if (cy == 0 && cx == -16) chk("addr_bm_y0", vif.vram_addr, 13'h0000);
        if (cy == 0 && cx == -14) chk("addr_at_y0", vif.vram_addr, 13'h1800);
        if (cy == 2 && cx == 16)  chk("addr_bm_y2", vif.vram_addr, 13'h0102);
        if (cy == 2 && cx == 18)  chk("addr_at_y2", vif.vram_addr, 13'h1802);
        if (cy == 16 && cx == -16) chk("addr_bm_y16", vif.vram_addr, 13'h0020);
        if (cy == 16 && cx == -14) chk("addr_at_y16", vif.vram_addr, 13'h1820);
        if (cy == 0 && (cx == 0 || cx == 1)) chk("pix_ink", {vga_r, vga_g, vga_b}, 12'hFFF);
        if (cy == 0 && cx >= 2 && cx <= 15) chk("pix_paper", {vga_r, vga_g, vga_b}, 12'h000);
      end
      if (lit_mode == 2 && cy == 0 && cx == 16)
        chk("flash", {vga_r, vga_g, vga_b}, ((c_fr % 32) >= 16) ? 12'hFFF : 12'h000);
      if (lit_mode == 3 && cy == 100 && (cx == -1 || cx == 520))
        chk("border_red", {vga_r, vga_g, vga_b}, 12'hB00);
      if (lit_mode == 4 && cy == 101 && cx == -1)
        chk("border_next", {vga_r, vga_g, vga_b}, 12'h00B);
      if (lit_mode == 4 && cy == 101 && cx == -20)
        chk("de_off", {vga_r, vga_g, vga_b}, 12'h000);
    end
  end

  int opt_xend = 535, opt_chg_x = -999, opt_de0_x = -999, opt_rst_x = -999;
  logic [2:0] opt_chg_b = '0;
  bit opt_rnd = 1'b0, opt_frame = 1'b0;

  task automatic run_line(input int y);
    for (int x = -24; x <= opt_xend; x++) begin
      @(posedge clk_pix); #1;
      sx = CORDW'(x); sy = CORDW'(y);
      line = (x == -24);
      frame = (x == -24) && opt_frame;
      if (frame) fr_sent++;
      if (opt_rnd && x == -24) border = 3'($urandom);
      if (x == opt_chg_x) border = opt_chg_b;
      de_in = opt_rnd ? ($urandom_range(0, 15) != 0) : 1'b1;
      if (x == opt_de0_x) de_in = 1'b0;
      hsync_in = !(x >= 520 && x < 530);
      rst = (x >= opt_rst_x && x < opt_rst_x + 3);
    end
  endtask

  task automatic blank(input int nfr);
    for (int k = 0; k < 2 * nfr + 2; k++) begin
      @(posedge clk_pix); #1;
      sx = CORDW'(600); de_in = 1'b0; line = 1'b0; rst = 1'b0;
      frame = (k % 2 == 0) && (k / 2 < nfr);
      if (frame) fr_sent++;
    end
  endtask

  initial begin
    for (int i = 0; i < 6912; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h80; mem[6144] = 8'h47;
    mem[1] = 8'h00; mem[6145] = 8'hC7;
    rst = 1'b1;
    repeat (3) begin
      sx = CORDW'($urandom); sy = CORDW'($urandom); de_in = 1'($urandom);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); frame = 1'($urandom);
      line = 1'($urandom); border = 3'($urandom);
      @(posedge clk_pix); #1;
    end
    rst = 1'b0; frame = 1'b0; line = 1'b0; de_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; fr_sent = 0;
    blank(0);

    lit_mode = 1;
    run_line(0); blank(0);
    run_line(2); blank(0);
    run_line(16); blank(0);

    lit_mode = 2; opt_xend = 40;
    for (int f = 0; f < 36; f++) begin
      run_line(0); blank(1);
    end
    opt_xend = 535;

    lit_mode = 3; border = 3'b010;
    opt_chg_x = 300; opt_chg_b = 3'b001;
    run_line(100); blank(0);
    lit_mode = 4; opt_chg_x = -999; opt_de0_x = -20;
    run_line(101); blank(0);
    opt_de0_x = -999;

    lit_mode = 0; opt_rnd = 1'b1;
    for (int n = 0; n < 50; n++) begin
      int ys;
      case ($urandom_range(0, 9))
        0: ys = -1;
        1: ys = 383;
        2: ys = 384;
        3: ys = 0;
        default: ys = $urandom_range(0, 383);
      endcase
      opt_chg_x = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 559) - 24 : -999;
      opt_chg_b = 3'($urandom);
      opt_frame = ($urandom_range(0, 3) == 0);
      opt_rst_x = (n == 25) ? 200 : -999;
      vsync_in = ($urandom_range(0, 7) != 0);
      run_line(ys);
      blank($urandom_range(0, 5));
      for (int k = 0; k < 64; k++) mem[$urandom_range(0, 6911)] = 8'($urandom);
    end

    @(posedge clk_pix); @(negedge clk_pix);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
